register_file_sb: RTL and testbench

// Parametrised multi-port register file with write-to-read bypass and a busy-bit scoreboard.

---
 rtl/register_file_sb_pkg.sv | 25 ++
 rtl/reg_scoreboard.sv | 75 +++++++
 rtl/register_file_sb.sv | 116 +++++++++++
 tb/tb_register_file_sb.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_sb_pkg.sv
// -----------------------------------------------------------------------------
// register_file_sb_pkg
// Shared constants and types for the MIPS32 integer register file.
//   DEF_*      default geometry of the register file
//   REG_ZERO   architectural zero register address
//   busy_op_e  per-register scoreboard action chosen for the next clock edge
// -----------------------------------------------------------------------------
package register_file_sb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_NUM_WR = 2;

    localparam int REG_ZERO   = 0;

    // Ordered from lowest to highest priority.
    typedef enum logic [1:0] {
        BUSY_HOLD  = 2'd0,
        BUSY_CLR   = 2'd1,
        BUSY_SET   = 2'd2,
        BUSY_FLUSH = 2'd3
    } busy_op_e;

endpackage

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Busy-bit scoreboard for the register file. One bit per register marks a
// destination reserved by issue and not yet committed by writeback.
// Ports:
//   clock, reset_n  rising-edge clock, asynchronous active-low reset
//   flush           clear every busy bit at the next edge
//   rsv_en/rsv_addr reserve one destination (sets its busy bit)
//   wr_hit          per-register "a write lands here this cycle" (already
//                   arbitrated and with the zero register removed)
//   busy            current busy bits
//   busy_cnt        registered population count of busy bits
// -----------------------------------------------------------------------------
module reg_scoreboard
    import register_file_sb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [(1<<ADDR_W)-1:0]   wr_hit,
    output logic [(1<<ADDR_W)-1:0]   busy,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    busy_op_e          op [DEPTH];
    logic [DEPTH-1:0]  busy_nxt;
    logic [ADDR_W:0]   cnt_nxt;

    // Reservation outranks a write to the same register: the reservation
    // belongs to a younger producer that has not written yet.
    always_comb begin
        busy_nxt = '0;
        cnt_nxt  = '0;
        for (int r = 0; r < DEPTH; r++) begin
            op[r] = BUSY_HOLD;
            if (flush) begin
                op[r] = BUSY_FLUSH;
            end else if (rsv_en && (rsv_addr == ADDR_W'(r))) begin
                op[r] = BUSY_SET;
            end else if (wr_hit[r]) begin
                op[r] = BUSY_CLR;
            end
            if (ZERO_REG && (r == REG_ZERO)) begin
                op[r] = BUSY_CLR;
            end

            case (op[r])
                BUSY_SET:   busy_nxt[r] = 1'b1;
                BUSY_HOLD:  busy_nxt[r] = busy[r];
                default:    busy_nxt[r] = 1'b0;
            endcase

            // Counting the next-state bits keeps busy_cnt aligned with busy.
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[r]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/register_file_sb.sv
// -----------------------------------------------------------------------------
// register_file_sb
// Multi-port integer register file with write-to-read bypass and a busy-bit
// scoreboard for the pipelined MIPS32 core.
// Ports:
//   clock, reset_n  rising-edge clock, asynchronous active-low reset
//   rd_addr/rd_data NUM_RD combinational read ports, port i at slice i
//   rd_busy         per read port: addressed register awaits a pending write
//   wr_en/wr_addr/wr_data  NUM_WR write ports; higher index wins conflicts
//   rsv_en/rsv_addr reserve a destination register (issue stage)
//   flush           clear all busy bits at the next edge, data kept
//   busy_cnt        registered count of busy registers
// -----------------------------------------------------------------------------
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs   [DEPTH];
    logic [DEPTH-1:0]  wr_hit;
    logic [DATA_W-1:0] wr_val [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [ADDR_W-1:0] ra     [NUM_RD];
    logic [NUM_RD-1:0] byp_hit;

    // Per-register write arbitration. Ports are scanned oldest to youngest so
    // the youngest matching port's data is the one left in wr_val.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < DEPTH; r++) begin
            wr_val[r] = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wr_data[j*DATA_W +: DATA_W];
                end
            end
            if (ZERO_REG && (r == REG_ZERO)) begin
                wr_hit[r] = 1'b0;
            end
        end
    end

    // Flop storage rather than RAM so reset can clear every register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_val[r];
                end
            end
        end
    end

    // Read ports. The bypass is gated by reset_n so that outputs are zero
    // while reset is held even if the write ports are active.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        byp_hit = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra[i]      = rd_addr[i*ADDR_W +: ADDR_W];
            byp_hit[i] = BYPASS && reset_n && wr_hit[ra[i]];
            if (ZERO_REG && (ra[i] == ADDR_W'(REG_ZERO))) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
            end else if (byp_hit[i]) begin
                rd_data[i*DATA_W +: DATA_W] = wr_val[ra[i]];
            end else begin
                rd_data[i*DATA_W +: DATA_W] = regs[ra[i]];
            end
            // A write landing this cycle satisfies the pending reservation
            // from the reader's point of view.
            rd_busy[i] = busy[ra[i]] & ~byp_hit[i];
        end
    end

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (flush),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wr_hit   (wr_hit),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

endmodule

// File: tb/tb_register_file_sb.sv
// -----------------------------------------------------------------------------
// tb_register_file_sb
// Self-checking bench for register_file_sb (32 x 32, 2 read, 2 write ports).
// Directed feature tasks followed by a randomized run against a behavioural
// model of the register contents and busy bits.
// -----------------------------------------------------------------------------
module tb_register_file_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int NREG = 32;

    logic              clock;
    logic              reset_n;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic              flush;
    logic [AW:0]       busy_cnt;

    int n_checks;
    int n_fail;

    // Behavioural model state.
    logic [DW-1:0] m_reg  [NREG];
    bit            m_busy [NREG];
    logic [AW:0]   exp_q  [$];

    register_file_sb dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- model ----------------
    task automatic model_clear();
        for (int r = 0; r < NREG; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = m_reg[a];
        for (int j = 0; j < NW; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*DW +: DW];
        return v;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        for (int j = 0; j < NW; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [AW:0] model_count();
        logic [AW:0] c;
        c = '0;
        for (int r = 0; r < NREG; r++) c = c + (AW+1)'(m_busy[r]);
        return c;
    endfunction

    // Apply the current inputs to the model as one clock edge would:
    // writes in port order, then reservation, then flush on top.
    task automatic model_commit();
        logic [AW-1:0] a;
        for (int j = 0; j < NW; j++) begin
            a = wr_addr[j*AW +: AW];
            if (wr_en[j] && a != 0) begin
                m_reg[a]  = wr_data[j*DW +: DW];
                m_busy[a] = 1'b0;
            end
        end
        if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        if (flush) for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        flush    = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[p]          = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_rsv(input logic [AW-1:0] a);
        rsv_en   = 1'b1;
        rsv_addr = a;
    endtask

    // Commit the current inputs at the next edge; return just after it.
    task automatic tick();
        model_commit();
        @(posedge clock);
        #1;
    endtask

    // ---------------- feature tests ----------------
    task automatic test_reset();
        // Some activity first so reset has something to clear.
        drive_idle();
        set_wr(0, 5'd12, 32'hCAFE_F00D);
        set_rsv(5'd13);
        tick();
        drive_idle();
        set_rsv(5'd14);
        tick();
        drive_idle();
        set_rd(0, 5'd12);
        set_rd(1, 5'd13);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (rd_data !== '0) begin
            n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data);
        end
        n_checks++;
        if (rd_busy !== '0) begin
            n_fail++; $display("FAIL reset_rd_busy: got %b expected 00", rd_busy);
        end
        n_checks++;
        if (busy_cnt !== '0) begin
            n_fail++; $display("FAIL reset_busy_cnt: got %0d expected 0", busy_cnt);
        end
        model_clear();
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if (rd_data[31:0] !== 32'h0) begin
            n_fail++; $display("FAIL reset_cleared_r12: got %h expected 0", rd_data[31:0]);
        end
    endtask

    task automatic test_write_read();
        drive_idle();
        set_wr(0, 5'd5, 32'hDEAD_BEEF);
        tick();
        drive_idle();
        set_rd(0, 5'd5);
        @(negedge clock);
        n_checks++;
        if (rd_data[31:0] !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL write_read_r5: got %h expected deadbeef", rd_data[31:0]);
        end
        tick();
    endtask

    task automatic test_bypass();
        // Reserve r7 first so the bypass also has to mask a busy bit.
        drive_idle();
        set_rsv(5'd7);
        tick();
        drive_idle();
        set_wr(0, 5'd7, 32'h0000_1234);
        set_rd(1, 5'd7);
        @(negedge clock);
        n_checks++;
        if (rd_data[63:32] !== 32'h0000_1234) begin
            n_fail++; $display("FAIL bypass_data: got %h expected 00001234", rd_data[63:32]);
        end
        n_checks++;
        if (rd_busy[1] !== 1'b0) begin
            n_fail++; $display("FAIL bypass_busy: got %b expected 0", rd_busy[1]);
        end
        tick();
    endtask

    task automatic test_conflict();
        drive_idle();
        set_wr(0, 5'd3, 32'h0000_AAAA);
        set_wr(1, 5'd3, 32'h0000_5555);
        set_rd(0, 5'd3);
        @(negedge clock);
        n_checks++;
        if (rd_data[31:0] !== 32'h0000_5555) begin
            n_fail++; $display("FAIL conflict_bypass: got %h expected 00005555", rd_data[31:0]);
        end
        tick();
        drive_idle();
        set_rd(0, 5'd3);
        set_wr(0, 5'd0, 32'h0000_FFFF);
        set_rd(1, 5'd0);
        @(negedge clock);
        n_checks++;
        if (rd_data[31:0] !== 32'h0000_5555) begin
            n_fail++; $display("FAIL conflict_r3: got %h expected 00005555", rd_data[31:0]);
        end
        n_checks++;
        if (rd_data[63:32] !== 32'h0) begin
            n_fail++; $display("FAIL zero_bypass: got %h expected 0", rd_data[63:32]);
        end
        tick();
        drive_idle();
        set_rd(1, 5'd0);
        @(negedge clock);
        n_checks++;
        if (rd_data[63:32] !== 32'h0) begin
            n_fail++; $display("FAIL zero_read: got %h expected 0", rd_data[63:32]);
        end
    endtask

    task automatic test_scoreboard();
        drive_idle();
        set_rsv(5'd9);
        tick();
        drive_idle();
        set_rd(0, 5'd9);
        @(negedge clock);
        n_checks++;
        if (rd_busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL sb_rsv_busy: got %b expected 1", rd_busy[0]);
        end
        n_checks++;
        if (busy_cnt !== 6'd1) begin
            n_fail++; $display("FAIL sb_rsv_cnt: got %0d expected 1", busy_cnt);
        end
        set_rsv(5'd9);
        set_wr(0, 5'd9, 32'h1111_2222);
        tick();
        drive_idle();
        set_rd(0, 5'd9);
        @(negedge clock);
        n_checks++;
        if (rd_busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL sb_rsv_wr_busy: got %b expected 1", rd_busy[0]);
        end
        n_checks++;
        if (busy_cnt !== 6'd1) begin
            n_fail++; $display("FAIL sb_rsv_wr_cnt: got %0d expected 1", busy_cnt);
        end
        set_wr(1, 5'd9, 32'h3333_4444);
        tick();
        drive_idle();
        set_rd(0, 5'd9);
        @(negedge clock);
        n_checks++;
        if (rd_busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL sb_wr_clear_busy: got %b expected 0", rd_busy[0]);
        end
        n_checks++;
        if (busy_cnt !== 6'd0) begin
            n_fail++; $display("FAIL sb_wr_clear_cnt: got %0d expected 0", busy_cnt);
        end
        n_checks++;
        if (rd_data[31:0] !== 32'h3333_4444) begin
            n_fail++; $display("FAIL sb_wr_data: got %h expected 33334444", rd_data[31:0]);
        end
        // Zero register can never be reserved.
        set_rsv(5'd0);
        tick();
        drive_idle();
        n_checks++;
        if (busy_cnt !== 6'd0) begin
            n_fail++; $display("FAIL sb_zero_rsv_cnt: got %0d expected 0", busy_cnt);
        end
    endtask

    task automatic test_flush();
        for (int r = 1; r <= 4; r++) begin
            drive_idle();
            set_rsv(AW'(r));
            tick();
        end
        drive_idle();
        n_checks++;
        if (busy_cnt !== 6'd4) begin
            n_fail++; $display("FAIL flush_pre_cnt: got %0d expected 4", busy_cnt);
        end
        flush = 1'b1;
        set_rsv(5'd6);
        tick();
        drive_idle();
        set_rd(0, 5'd6);
        set_rd(1, 5'd2);
        @(negedge clock);
        n_checks++;
        if (busy_cnt !== 6'd0) begin
            n_fail++; $display("FAIL flush_cnt: got %0d expected 0", busy_cnt);
        end
        n_checks++;
        if (rd_busy !== 2'b00) begin
            n_fail++; $display("FAIL flush_busy: got %b expected 00", rd_busy);
        end
        n_checks++;
        if (rd_data[63:32] !== 32'h0) begin
            n_fail++; $display("FAIL flush_data_kept: got %h expected 0", rd_data[63:32]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [AW:0]   exp_cnt;
        logic [AW-1:0] a;
        for (int c = 0; c < 400; c++) begin
            drive_idle();
            // Narrow address range half the time to force conflicts and bypass.
            for (int j = 0; j < NW; j++) begin
                if ($urandom_range(0, 1) == 1) begin
                    a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7))
                                                    : AW'($urandom_range(0, NREG-1));
                    set_wr(j, a, $urandom);
                end
            end
            for (int i = 0; i < NR; i++) begin
                a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7))
                                                : AW'($urandom_range(0, NREG-1));
                set_rd(i, a);
            end
            if ($urandom_range(0, 2) != 0)
                set_rsv(($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7))
                                                    : AW'($urandom_range(0, NREG-1)));
            flush = ($urandom_range(0, 24) == 0);
            @(negedge clock);
            for (int i = 0; i < NR; i++) begin
                a = rd_addr[i*AW +: AW];
                n_checks++;
                if (rd_data[i*DW +: DW] !== exp_data(a)) begin
                    n_fail++;
                    $display("FAIL rand_rd_data[%0d] cycle %0d addr %0d: got %h expected %h",
                             i, c, a, rd_data[i*DW +: DW], exp_data(a));
                end
                n_checks++;
                if (rd_busy[i] !== exp_busy(a)) begin
                    n_fail++;
                    $display("FAIL rand_rd_busy[%0d] cycle %0d addr %0d: got %b expected %b",
                             i, c, a, rd_busy[i], exp_busy(a));
                end
            end
            tick();
            exp_q.push_back(model_count());
            exp_cnt = exp_q.pop_front();
            n_checks++;
            if (busy_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL rand_busy_cnt cycle %0d: got %0d expected %0d", c, busy_cnt, exp_cnt);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        drive_idle();
        model_clear();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        @(posedge clock);
        #1;

        test_reset();
        test_write_read();
        test_bypass();
        test_conflict();
        test_scoreboard();
        test_flush();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
